// File: rtl/spi_eeprom_slave_if.sv
// SPI bus plus write-observation signals between an EEPROM master and the
// spi_eeprom_slave responder.
interface spi_eeprom_slave_if;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       wel;
    logic       wip;
    logic       wr_strobe;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output sclk, ss_n, mosi,
        input  miso, miso_oe, wel, wip, wr_strobe, wr_addr, wr_data
    );

    modport slave (
        input  sclk, ss_n, mosi,
        output miso, miso_oe, wel, wip, wr_strobe, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 responder emulating a 512-byte 25xx040-style EEPROM.
// Define WRITE_CYCLE_EN to model the internal write time (busy window on wip).
module spi_eeprom_slave #(
    parameter int MEM_BYTES        = 512,
    parameter int PAGE_BYTES       = 16,
    parameter int SYNC_STAGES      = 2,
    parameter int WRITE_CYCLE_CLKS = 1000
) (
    input  logic               clk,
    input  logic               reset,
    spi_eeprom_slave_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, IGNORE} state_t;

    localparam logic [8:0] PAGE_MASK = 9'(PAGE_BYTES - 1);

    // Synchronizer chain carrying {sclk, ss_n, mosi}; ss_n resets high so no false select.
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] q;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (reset) q <= 3'b010;
                else       q <= {bus.sclk, bus.ss_n, bus.mosi};
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (reset) q <= 3'b010;
                else       q <= g_sync[gi-1].q;
            end
        end
    end

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_prev_q, ss_prev_q;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise, byte_done, write_end_w, wip_w;
    logic [7:0] byte_d, status_d, load_d;
    logic [8:0] addr_inc_d, addr_page_d;

    state_t     state_q;
    logic [2:0] bit_cnt_q, out_cnt_q;
    logic [6:0] sh_in_q;
    logic [7:0] sh_out_q, rd_data_q;
    logic [8:0] addr_q, wr_addr_q;
    logic [7:0] wr_data_q;
    logic       is_rd_q, wel_q, committed_q, miso_q, miso_oe_q, wr_strobe_q;
    logic [7:0] mem_q [MEM_BYTES];

    assign sclk_s      = g_sync[SYNC_STAGES-1].q[2];
    assign ss_s        = g_sync[SYNC_STAGES-1].q[1];
    assign mosi_s      = g_sync[SYNC_STAGES-1].q[0];
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign ss_fall     = ~ss_s & ss_prev_q;
    assign ss_rise     = ss_s & ~ss_prev_q;
    assign byte_d      = {sh_in_q, mosi_s};
    assign byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
    assign write_end_w = ss_rise && committed_q;
    assign addr_inc_d  = addr_q + 9'd1;
    assign addr_page_d = (addr_q & ~PAGE_MASK) | (addr_inc_d & PAGE_MASK);
    assign status_d    = {6'b0, wel_q, wip_w};
    assign load_d      = (state_q == RDSR) ? status_d : rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

`ifdef WRITE_CYCLE_EN
    logic        wip_q;
    logic [31:0] wip_cnt_q;
    logic        wip_done_w;
    assign wip_done_w = wip_q && (wip_cnt_q == 32'd0);
    assign wip_w      = wip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wip_q     <= 1'b0;
            wip_cnt_q <= 32'd0;
        end else if (write_end_w) begin
            wip_q     <= 1'b1;
            wip_cnt_q <= 32'(WRITE_CYCLE_CLKS - 1);
        end else if (wip_q) begin
            if (wip_cnt_q == 32'd0) wip_q <= 1'b0;
            else                    wip_cnt_q <= wip_cnt_q - 32'd1;
        end
    end
`else
    // No busy window in this build; wip is constant low.
    assign wip_w = (WRITE_CYCLE_CLKS < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            out_cnt_q   <= 3'd0;
            sh_in_q     <= 7'd0;
            sh_out_q    <= 8'd0;
            addr_q      <= 9'd0;
            is_rd_q     <= 1'b0;
            wel_q       <= 1'b0;
            committed_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 9'd0;
            wr_data_q   <= 8'd0;
        end else begin
            wr_strobe_q <= 1'b0;
`ifdef WRITE_CYCLE_EN
            if (wip_done_w) wel_q <= 1'b0;
`else
            if (write_end_w) wel_q <= 1'b0;
`endif
            if (ss_s) begin
                // Deselect beats any same-cycle sclk edge and drops partial bytes.
                state_q   <= IDLE;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
                if (ss_rise) committed_q <= 1'b0;
            end else if (ss_fall) begin
                state_q     <= CMD;
                bit_cnt_q   <= 3'd0;
                committed_q <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    sh_in_q   <= byte_d[6:0];
                end
                case (state_q)
                    CMD: if (byte_done) begin
                        if (wip_w && byte_d != 8'h05) begin
                            state_q <= IGNORE;
                        end else begin
                            casez (byte_d)
                                8'h06: begin wel_q <= 1'b1; state_q <= IGNORE; end
                                8'h04: begin wel_q <= 1'b0; state_q <= IGNORE; end
                                8'h05: begin
                                    state_q   <= RDSR;
                                    miso_oe_q <= 1'b1;
                                    out_cnt_q <= 3'd0;
                                end
                                8'b0000_?011: begin
                                    addr_q[8] <= byte_d[3];
                                    is_rd_q   <= 1'b1;
                                    state_q   <= ADDR;
                                end
                                8'b0000_?010: begin
                                    addr_q[8] <= byte_d[3];
                                    is_rd_q   <= 1'b0;
                                    state_q   <= wel_q ? ADDR : IGNORE;
                                end
                                default: state_q <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (byte_done) begin
                        addr_q[7:0] <= byte_d;
                        if (is_rd_q) begin
                            state_q   <= RD_DATA;
                            miso_oe_q <= 1'b1;
                            out_cnt_q <= 3'd0;
                        end else begin
                            state_q <= WR_DATA;
                        end
                    end
                    RD_DATA, RDSR: if (sclk_fall) begin
                        // Bit 0 of each byte is a fresh load; the read address advances right away
                        // so the registered array read is ready eight falls later.
                        if (out_cnt_q == 3'd0) begin
                            miso_q   <= load_d[7];
                            sh_out_q <= {load_d[6:0], 1'b0};
                            if (state_q == RD_DATA) addr_q <= addr_inc_d;
                        end else begin
                            miso_q   <= sh_out_q[7];
                            sh_out_q <= {sh_out_q[6:0], 1'b0};
                        end
                        out_cnt_q <= out_cnt_q + 3'd1;
                    end
                    WR_DATA: if (byte_done) begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= addr_q;
                        wr_data_q   <= byte_d;
                        addr_q      <= addr_page_d;
                        committed_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_strobe_q) mem_q[wr_addr_q] <= wr_data_q;
        rd_data_q <= mem_q[addr_q];
    end

    assign bus.miso      = miso_q & miso_oe_q;
    assign bus.miso_oe   = miso_oe_q;
    assign bus.wel       = wel_q;
    assign bus.wip       = wip_w;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed, table-driven bench for spi_eeprom_slave acting as an SPI mode-0 master.
module tb_spi_eeprom_slave;
`ifdef WRITE_CYCLE_EN
    localparam int TB_WC = 2000;
`else
    localparam int TB_WC = 1000;
`endif
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_eeprom_slave_if bus();

    spi_eeprom_slave #(.WRITE_CYCLE_CLKS(TB_WC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        string       name;
        int          len;
        logic [47:0] tx;
        logic [5:0]  rx_chk;
        logic [47:0] rx_exp;
        logic [5:0]  oe_exp;
        int          n_wr;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   wr_idx = 0;
    logic miso_leak;
    wr_t  wr_q[$];
    wr_t  exp_wr[10];
    vec_t vecs[22];

    always @(negedge clk) begin
        if (bus.wr_strobe) wr_q.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_start();
        bus.ss_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_stop();
        wait_clks(HALF);
        bus.ss_n = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_all);
        rx     = 8'd0;
        oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            wait_clks(HALF);
            bus.sclk = 1'b1;
            rx       = {rx[6:0], bus.miso};
            oe_all   = oe_all & bus.miso_oe;
            if (!bus.miso_oe && bus.miso) miso_leak = 1'b1;
            wait_clks(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        logic       oe;
        int         n;
        miso_leak = 1'b0;
        wr_q.delete();
        spi_start();
        for (int i = 0; i < v.len; i++) begin
            spi_bits(v.tx[47-8*i -: 8], 8, rx, oe);
            check({v.name, "_oe"}, 32'(oe), 32'(v.oe_exp[i]));
            if (v.rx_chk[i]) check({v.name, "_rx"}, 32'(rx), 32'(v.rx_exp[47-8*i -: 8]));
        end
        spi_stop();
        check({v.name, "_leak"}, 32'(miso_leak), 32'd0);
        n = wr_q.size();
        check({v.name, "_nwr"}, 32'(n), 32'(v.n_wr));
        for (int k = 0; k < n && k < v.n_wr; k++) begin
            check({v.name, "_wr"}, 32'(wr_q[k]), 32'(exp_wr[wr_idx]));
            wr_idx++;
        end
    endtask

    task automatic partial_txn(input logic [7:0] b0, input logic [7:0] b1,
                               input int nfull, input int tail_bits);
        logic [7:0] rx;
        logic       oe;
        wr_q.delete();
        spi_start();
        if (nfull > 0) spi_bits(b0, 8, rx, oe);
        if (nfull > 1) spi_bits(b1, 8, rx, oe);
        spi_bits(8'h55, tail_bits, rx, oe);
        spi_stop();
    endtask

    localparam vec_t V_WREN = '{"wren", 1, 48'h06_0000000000, 6'b0, 48'h0, 6'b0, 0};
    localparam vec_t V_WRDI = '{"wrdi", 1, 48'h04_0000000000, 6'b0, 48'h0, 6'b0, 0};

    initial begin
        exp_wr[0] = '{9'h123, 8'h5A};
        exp_wr[1] = '{9'h124, 8'hC3};
        exp_wr[2] = '{9'h01E, 8'h11};
        exp_wr[3] = '{9'h01F, 8'h22};
        exp_wr[4] = '{9'h010, 8'h33};
        exp_wr[5] = '{9'h1FF, 8'hAA};
        exp_wr[6] = '{9'h1F0, 8'hBB};
        exp_wr[7] = '{9'h000, 8'hCC};
        exp_wr[8] = '{9'h040, 8'h99};
        exp_wr[9] = '{9'h050, 8'h12};

        vecs[0]  = '{"rdsr_reset",   2, 48'h05_00_00000000, 6'b000010, 48'h00_00_00000000, 6'b000010, 0};
        vecs[1]  = V_WREN;
        vecs[2]  = '{"rdsr_wel",     2, 48'h05_00_00000000, 6'b000010, 48'h00_02_00000000, 6'b000010, 0};
        vecs[3]  = V_WRDI;
        vecs[4]  = '{"rdsr_wrdi",    2, 48'h05_00_00000000, 6'b000010, 48'h00_00_00000000, 6'b000010, 0};
        vecs[5]  = V_WREN;
        vecs[6]  = '{"write_123",    4, 48'h0A_23_5A_C3_0000, 6'b0, 48'h0, 6'b0, 2};
        vecs[7]  = '{"read_123",     4, 48'h0B_23_00_00_0000, 6'b001100, 48'h0000_5A_C3_0000, 6'b001100, 0};
        vecs[8]  = '{"rdsr_autoclr", 2, 48'h05_00_00000000, 6'b000010, 48'h00_00_00000000, 6'b000010, 0};
        vecs[9]  = V_WREN;
        vecs[10] = '{"write_wrap",   5, 48'h02_1E_11_22_33_00, 6'b0, 48'h0, 6'b0, 3};
        vecs[11] = '{"read_01e",     4, 48'h03_1E_00_00_0000, 6'b001100, 48'h0000_11_22_0000, 6'b001100, 0};
        vecs[12] = '{"read_010",     3, 48'h03_10_00_000000, 6'b000100, 48'h0000_33_000000, 6'b000100, 0};
        vecs[13] = V_WREN;
        vecs[14] = '{"write_1ff",    4, 48'h0A_FF_AA_BB_0000, 6'b0, 48'h0, 6'b0, 2};
        vecs[15] = V_WREN;
        vecs[16] = '{"write_000",    3, 48'h02_00_CC_000000, 6'b0, 48'h0, 6'b0, 1};
        vecs[17] = '{"read_wrap",    4, 48'h0B_FF_00_00_0000, 6'b001100, 48'h0000_AA_CC_0000, 6'b001100, 0};
        vecs[18] = V_WREN;
        vecs[19] = '{"write_040",    3, 48'h02_40_99_000000, 6'b0, 48'h0, 6'b0, 1};
        vecs[20] = '{"write_no_wel", 3, 48'h02_40_77_000000, 6'b0, 48'h0, 6'b0, 0};
        vecs[21] = '{"read_040",     3, 48'h03_40_00_000000, 6'b000100, 48'h0000_99_000000, 6'b000100, 0};

        reset    = 1'b1;
        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(2);

        check("rst_miso",      32'(bus.miso),      32'd0);
        check("rst_miso_oe",   32'(bus.miso_oe),   32'd0);
        check("rst_wel",       32'(bus.wel),       32'd0);
        check("rst_wip",       32'(bus.wip),       32'd0);
        check("rst_wr_strobe", 32'(bus.wr_strobe), 32'd0);
        check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
        check("rst_wr_data",   32'(bus.wr_data),   32'd0);

        for (int i = 0; i < 22; i++) begin
            run_vec(vecs[i]);
            $display("txn %0d %s done: checks=%0d errors=%0d", i, vecs[i].name, checks, errors);
        end

        // Write aborted after 5 data bits: nothing commits and wel survives.
        run_vec(V_WREN);
        partial_txn(8'h02, 8'h40, 2, 5);
        check("abort_nwr", 32'(wr_q.size()), 32'd0);
        check("abort_wel_pin", 32'(bus.wel), 32'd1);
        run_vec('{"rdsr_abort", 2, 48'h05_00_00000000, 6'b000010, 48'h00_02_00000000, 6'b000010, 0});
        run_vec('{"read_040b", 3, 48'h03_40_00_000000, 6'b000100, 48'h0000_99_000000, 6'b000100, 0});
        $display("txn aborted write done: checks=%0d errors=%0d", checks, errors);

        // Opcode aborted after 7 bits must not set wel.
        run_vec(V_WRDI);
        partial_txn(8'h00, 8'h00, 0, 7);
        check("abort_op_wel_pin", 32'(bus.wel), 32'd0);
        spi_start();
        begin
            logic [7:0] rx;
            logic       oe;
            miso_leak = 1'b0;
            spi_bits(8'h06 << 1, 7, rx, oe);
        end
        spi_stop();
        check("abort_wren_wel_pin", 32'(bus.wel), 32'd0);
        run_vec('{"rdsr_abort_op", 2, 48'h05_00_00000000, 6'b000010, 48'h00_00_00000000, 6'b000010, 0});
        $display("txn aborted opcode done: checks=%0d errors=%0d", checks, errors);

`ifdef WRITE_CYCLE_EN
        run_vec(V_WREN);
        run_vec('{"write_050", 3, 48'h02_50_12_000000, 6'b0, 48'h0, 6'b0, 1});
        check("busy_wip_pin", 32'(bus.wip), 32'd1);
        run_vec('{"rdsr_busy", 2, 48'h05_00_00000000, 6'b000010, 48'h00_03_00000000, 6'b000010, 0});
        run_vec('{"read_busy", 3, 48'h03_50_00_000000, 6'b0, 48'h0, 6'b0, 0});
        wait_clks(TB_WC);
        check("idle_wip_pin", 32'(bus.wip), 32'd0);
        run_vec('{"rdsr_done", 2, 48'h05_00_00000000, 6'b000010, 48'h00_00_00000000, 6'b000010, 0});
        run_vec('{"read_050", 3, 48'h03_50_00_000000, 6'b000100, 48'h0000_12_000000, 6'b000100, 0});
        $display("txn write cycle done: checks=%0d errors=%0d", checks, errors);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
